rgb_pwm_driver: RTL and testbench

Downstream stage of the colour-phase/intensity generator. It accepts 8-bit R/G/B intensity samples over a valid/ready handshake and holds them in a one-entry pending buffer. Samples are committed to the active duty registers only at a PWM period boundary, so duty updates never glitch mid-period. The block drives the active-low RGB LED pins with per-channel gain via right shift.

---
 rtl/rgb_pwm_driver.sv | 175 +++++++++++++++++
 tb/tb_rgb_pwm_driver.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_driver.sv
// -----------------------------------------------------------------------------
// rgb_pwm_driver
//
// Purpose:
//   Final stage after the colour-phase/intensity generator. Takes 8-bit R/G/B
//   intensity samples over a valid/ready handshake into a one-entry pending
//   buffer. The pending sample is moved into the active duty registers only
//   when the PWM counter wraps, so the on-time of a period is never changed
//   part-way through it. Each channel has a fixed gain (a right shift) to
//   balance the perceived brightness of the three LED dies.
//
// Ports:
//   iCLOCK         in   system clock, all state on its rising edge
//   iRESET         in   synchronous reset, active-high
//   iVALID         in   intensity sample valid
//   oREADY         out  pending buffer empty, sample may be accepted
//   iR/iG/iB       in   PWM_BITS intensity per channel
//   iENABLE        in   1 = LEDs driven, 0 = all LEDs forced off
//   oLED[2:0]      out  active-low pins, [2]=R, [1]=G, [0]=B
//   oPERIOD_START  out  one-cycle pulse, first cycle of each PWM period
// -----------------------------------------------------------------------------
module rgb_pwm_driver #(
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 1,
    parameter int R_SHIFT  = 1,
    parameter int G_SHIFT  = 3,
    parameter int B_SHIFT  = 0
) (
    input  logic                iCLOCK,
    input  logic                iRESET,
    input  logic                iVALID,
    output logic                oREADY,
    input  logic [PWM_BITS-1:0] iR,
    input  logic [PWM_BITS-1:0] iG,
    input  logic [PWM_BITS-1:0] iB,
    input  logic                iENABLE,
    output logic [2:0]          oLED,
    output logic                oPERIOD_START
);

    localparam int                PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]   PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] CNT_LAST = '1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PS_W-1:0]     presc_q,  presc_d;
    logic [PWM_BITS-1:0] cnt_q,    cnt_d;

    logic                pend_full_q, pend_full_d;
    logic [PWM_BITS-1:0] pend_r_q, pend_r_d;
    logic [PWM_BITS-1:0] pend_g_q, pend_g_d;
    logic [PWM_BITS-1:0] pend_b_q, pend_b_d;

    logic [PWM_BITS-1:0] duty_r_q, duty_r_d;
    logic [PWM_BITS-1:0] duty_g_q, duty_g_d;
    logic [PWM_BITS-1:0] duty_b_q, duty_b_d;

    logic                ready_q,  ready_d;
    logic                pstart_q, pstart_d;
    logic [2:0]          led_q,    led_d;

    // ------------------------------------------------------------------
    // Control strobes
    // ------------------------------------------------------------------
    logic tick;
    logic boundary;
    logic accept;
    logic commit;

    always_comb begin
        tick     = (presc_q == PS_LAST);
        boundary = tick && (cnt_q == CNT_LAST);
        accept   = iVALID && ready_q;
        // Only a sample that was already pending at the start of the cycle
        // may commit; a sample accepted on the boundary waits a full period.
        commit   = boundary && pend_full_q;
    end

    // ------------------------------------------------------------------
    // Prescaler and PWM counter
    // ------------------------------------------------------------------
    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        cnt_d   = tick ? cnt_q + 1'b1 : cnt_q;
    end

    // ------------------------------------------------------------------
    // Pending buffer and handshake
    // ------------------------------------------------------------------
    always_comb begin
        pend_full_d = pend_full_q;
        pend_r_d    = pend_r_q;
        pend_g_d    = pend_g_q;
        pend_b_d    = pend_b_q;

        // commit and accept are mutually exclusive: accept needs an empty
        // buffer, commit needs a full one.
        if (commit) begin
            pend_full_d = 1'b0;
        end else if (accept) begin
            pend_full_d = 1'b1;
            pend_r_d    = iR;
            pend_g_d    = iG;
            pend_b_d    = iB;
        end

        ready_d = !pend_full_d;
    end

    // ------------------------------------------------------------------
    // Active duty registers, loaded only at the period boundary
    // ------------------------------------------------------------------
    always_comb begin
        duty_r_d = duty_r_q;
        duty_g_d = duty_g_q;
        duty_b_d = duty_b_q;
        if (commit) begin
            duty_r_d = pend_r_q >> R_SHIFT;
            duty_g_d = pend_g_q >> G_SHIFT;
            duty_b_d = pend_b_q >> B_SHIFT;
        end
    end

    // ------------------------------------------------------------------
    // Compare stage. Strict less-than: duty 0 never lights, full-scale
    // duty leaves the channel dark for exactly one step per period.
    // Pins are active-low.
    // ------------------------------------------------------------------
    always_comb begin
        led_d[2] = !(iENABLE && (cnt_q < duty_r_q));
        led_d[1] = !(iENABLE && (cnt_q < duty_g_q));
        led_d[0] = !(iENABLE && (cnt_q < duty_b_q));
        pstart_d = boundary;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            presc_q     <= '0;
            cnt_q       <= '0;
            pend_full_q <= 1'b0;
            pend_r_q    <= '0;
            pend_g_q    <= '0;
            pend_b_q    <= '0;
            duty_r_q    <= '0;
            duty_g_q    <= '0;
            duty_b_q    <= '0;
            ready_q     <= 1'b0;
            pstart_q    <= 1'b0;
            led_q       <= 3'b111;
        end else begin
            presc_q     <= presc_d;
            cnt_q       <= cnt_d;
            pend_full_q <= pend_full_d;
            pend_r_q    <= pend_r_d;
            pend_g_q    <= pend_g_d;
            pend_b_q    <= pend_b_d;
            duty_r_q    <= duty_r_d;
            duty_g_q    <= duty_g_d;
            duty_b_q    <= duty_b_d;
            ready_q     <= ready_d;
            pstart_q    <= pstart_d;
            led_q       <= led_d;
        end
    end

    assign oREADY        = ready_q;
    assign oLED          = led_q;
    assign oPERIOD_START = pstart_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// -----------------------------------------------------------------------------
// tb_rgb_pwm_driver
//
// Two instances share one clock: dut0 with PRESCALE=1, dut1 with PRESCALE=4.
// A reference model derives the PWM counter from the number of clock edges
// since reset, and commits pending samples when that edge count reaches a
// multiple of the period length. Every cycle, every output of both
// instances is compared against it; directed steps add period-level checks
// (low-time counts, pulse spacing).
// -----------------------------------------------------------------------------
module tb_rgb_pwm_driver;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } samp_t;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst;
    logic [1:0] vld;
    logic [1:0] en;
    logic [7:0] ir [2];
    logic [7:0] ig [2];
    logic [7:0] ib [2];

    logic       rdy0, rdy1, ps0, ps1;
    logic [2:0] led0, led1;

    rgb_pwm_driver #(.PWM_BITS(8), .PRESCALE(1), .R_SHIFT(1), .G_SHIFT(3), .B_SHIFT(0)) dut0 (
        .iCLOCK(clk), .iRESET(rst[0]), .iVALID(vld[0]), .oREADY(rdy0),
        .iR(ir[0]), .iG(ig[0]), .iB(ib[0]), .iENABLE(en[0]),
        .oLED(led0), .oPERIOD_START(ps0)
    );

    rgb_pwm_driver #(.PWM_BITS(8), .PRESCALE(4), .R_SHIFT(1), .G_SHIFT(3), .B_SHIFT(0)) dut1 (
        .iCLOCK(clk), .iRESET(rst[1]), .iVALID(vld[1]), .oREADY(rdy1),
        .iR(ir[1]), .iG(ig[1]), .iB(ib[1]), .iENABLE(en[1]),
        .oLED(led1), .oPERIOD_START(ps1)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state (per instance)
    int         k     [2];      // clock edges since reset released
    int         duty  [2][3];   // active duty R,G,B
    int         pv    [2][3];   // pending sample R,G,B
    bit         pend  [2];
    bit         m_rdy [2];
    bit         m_ps  [2];
    logic [2:0] m_led [2];
    int         SH    [3] = '{1, 3, 0};
    int         PRE   [2] = '{1, 4};

    samp_t q0[$];
    samp_t q1[$];

    function automatic logic [2:0] get_led(input int d);
        return (d == 0) ? led0 : led1;
    endfunction
    function automatic logic get_rdy(input int d);
        return (d == 0) ? rdy0 : rdy1;
    endfunction
    function automatic logic get_ps(input int d);
        return (d == 0) ? ps0 : ps1;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int d, input int r, input int g, input int b);
        samp_t s;
        s.r = 8'(r);
        s.g = 8'(g);
        s.b = 8'(b);
        if (d == 0) q0.push_back(s);
        else        q1.push_back(s);
    endtask

    task automatic model_edge(input int d);
        int  cnt;
        int  per;
        bit  acc;
        bit  bnd;
        if (rst[d]) begin
            k[d]    = 0;
            pend[d] = 1'b0;
            m_rdy[d] = 1'b0;
            m_ps[d]  = 1'b0;
            m_led[d] = 3'b111;
            for (int c = 0; c < 3; c++) duty[d][c] = 0;
        end else begin
            per = 256 * PRE[d];
            cnt = (k[d] / PRE[d]) % 256;
            for (int c = 0; c < 3; c++)
                m_led[d][2-c] = (en[d] && (cnt < duty[d][c])) ? 1'b0 : 1'b1;
            acc  = vld[d] && m_rdy[d];
            k[d] = k[d] + 1;
            bnd  = (k[d] % per) == 0;
            if (bnd && pend[d]) begin
                for (int c = 0; c < 3; c++) duty[d][c] = pv[d][c] >> SH[c];
                pend[d] = 1'b0;
            end
            if (acc) begin
                pend[d]  = 1'b1;
                pv[d][0] = int'(ir[d]);
                pv[d][1] = int'(ig[d]);
                pv[d][2] = int'(ib[d]);
                if (d == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
            end
            m_rdy[d] = !pend[d];
            m_ps[d]  = bnd;
        end
    endtask

    // One clock cycle: present source data, advance model, check all outputs.
    task automatic step();
        if (q0.size() > 0) begin
            vld[0] = 1'b1; ir[0] = q0[0].r; ig[0] = q0[0].g; ib[0] = q0[0].b;
        end else begin
            vld[0] = 1'b0;
        end
        if (q1.size() > 0) begin
            vld[1] = 1'b1; ir[1] = q1[0].r; ig[1] = q1[0].g; ib[1] = q1[0].b;
        end else begin
            vld[1] = 1'b0;
        end
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        chk("led0", 16'(led0), 16'(m_led[0]));
        chk("rdy0", 16'(rdy0), 16'(m_rdy[0]));
        chk("ps0",  16'(ps0),  16'(m_ps[0]));
        chk("led1", 16'(led1), 16'(m_led[1]));
        chk("rdy1", 16'(rdy1), 16'(m_rdy[1]));
        chk("ps1",  16'(ps1),  16'(m_ps[1]));
    endtask

    task automatic wait_ps(input int d, input int budget, input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (get_ps(d) !== 1'b1 && n < budget);
        chk(tag, 16'(get_ps(d)), 16'd1);
    endtask

    task automatic count_low(input int d, input int n, output int cr, output int cg, output int cb);
        logic [2:0] l;
        cr = 0; cg = 0; cb = 0;
        for (int i = 0; i < n; i++) begin
            step();
            l = get_led(d);
            if (l[2] == 1'b0) cr++;
            if (l[1] == 1'b0) cg++;
            if (l[0] == 1'b0) cb++;
        end
    endtask

    initial begin
        int cr, cg, cb, n;
        int sr, sg, sb;

        rst = 2'b11; vld = 2'b00; en = 2'b11;
        for (int d = 0; d < 2; d++) begin
            ir[d] = 8'h00; ig[d] = 8'h00; ib[d] = 8'h00;
        end

        // Reset and release
        repeat (3) step();
        chk("rst_led0", 16'(led0), 16'd7);
        chk("rst_rdy0", 16'(rdy0), 16'd0);
        chk("rst_ps0",  16'(ps0),  16'd0);
        rst = 2'b00;
        step();
        chk("rdy_after_rst", 16'(rdy0), 16'd1);

        // Idle: LEDs dark, period pulse every 256 cycles
        wait_ps(0, 300, "first_ps");
        n = 0;
        do begin step(); n++; end while (ps0 !== 1'b1 && n < 600);
        chk("ps_interval", 16'(n), 16'd256);

        // Full-scale sample with per-channel gain
        repeat (10) step();
        push(0, 255, 255, 255);
        step();
        chk("rdy_after_accept", 16'(rdy0), 16'd0);
        wait_ps(0, 300, "commit_full");
        count_low(0, 256, cr, cg, cb);
        chk("full_r_low", 16'(cr), 16'd127);
        chk("full_g_low", 16'(cg), 16'd31);
        chk("full_b_low", 16'(cb), 16'd255);

        // Back-to-back samples: second held off until the next boundary
        push(0, 8'h80, 8'h00, 8'h40);
        push(0, 8'h10, 8'h10, 8'h10);
        step();
        step();
        chk("b2b_held_off", 16'(rdy0), 16'd0);
        wait_ps(0, 300, "commit_a");
        count_low(0, 256, cr, cg, cb);
        chk("a_r_low", 16'(cr), 16'd64);
        chk("a_g_low", 16'(cg), 16'd0);
        chk("a_b_low", 16'(cb), 16'd64);
        count_low(0, 256, cr, cg, cb);
        chk("b_r_low", 16'(cr), 16'd8);
        chk("b_g_low", 16'(cg), 16'd2);
        chk("b_b_low", 16'(cb), 16'd16);

        // Sample accepted exactly on the boundary waits one full period
        n = 0;
        while (((k[0] + 1) % 256) != 0 && n < 300) begin step(); n++; end
        sr = $urandom_range(1, 255); sg = $urandom_range(16, 255); sb = $urandom_range(1, 255);
        push(0, sr, sg, sb);
        step();
        chk("bnd_accept_ps",  16'(ps0),  16'd1);
        chk("bnd_accept_rdy", 16'(rdy0), 16'd0);
        count_low(0, 256, cr, cg, cb);
        chk("bnd_old_r", 16'(cr), 16'd8);
        chk("bnd_old_g", 16'(cg), 16'd2);
        chk("bnd_old_b", 16'(cb), 16'd16);
        count_low(0, 256, cr, cg, cb);
        chk("bnd_new_r", 16'(cr), 16'(sr / 2));
        chk("bnd_new_g", 16'(cg), 16'(sg / 8));
        chk("bnd_new_b", 16'(cb), 16'(sb));

        // Enable dropped mid-period, then restored without counter restart
        push(0, 0, 0, 200);
        wait_ps(0, 600, "commit_b200");
        repeat (50) step();
        en[0] = 1'b0;
        step();
        chk("en_off_led", 16'(led0), 16'd7);
        repeat (20) step();
        en[0] = 1'b1;
        step();
        chk("reen_b_on", 16'(led0[0]), 16'd0);
        n = 0;
        do begin step(); n++; end while (ps0 !== 1'b1 && n < 600);
        chk("reen_no_restart", 16'(n), 16'd184);

        // PRESCALE=4 instance: 1024-cycle period, B=8 low for 32 cycles
        push(1, 0, 0, 8);
        wait_ps(1, 2100, "p4_commit");
        count_low(1, 1024, cr, cg, cb);
        chk("p4_r_low", 16'(cr), 16'd0);
        chk("p4_g_low", 16'(cg), 16'd0);
        chk("p4_b_low", 16'(cb), 16'd32);
        repeat (300) step();
        rst[1] = 1'b1;
        step();
        chk("p4_rst_led", 16'(led1), 16'd7);
        chk("p4_rst_rdy", 16'(rdy1), 16'd0);
        step();
        chk("p4_rst_rdy2", 16'(rdy1), 16'd0);
        rst[1] = 1'b0;
        step();
        chk("p4_rdy_after", 16'(rdy1), 16'd1);
        count_low(1, 1024, cr, cg, cb);
        chk("p4_cleared_b", 16'(cb), 16'd0);
        chk("p4_cleared_r", 16'(cr), 16'd0);

        // Randomised samples, gaps and enable on dut0
        for (int i = 0; i < 10; i++) begin
            push(0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            en[0] = ($urandom_range(0, 3) != 0);
            n = $urandom_range(0, 600);
            for (int j = 0; j < n; j++) step();
        end
        en[0] = 1'b1;
        repeat (700) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
